// File: rtl/zipomem.sv
// zipomem: word-addressed 64-bit memory responder for the zipocpu bus.
//
// After reset, a loader fills the array from a valid/ready stream. The FSM
// enters RUN after the word flagged by ld_last, or after the word that fills
// the last array index. In RUN, every cycle performs one CPU access, either a
// read or a read-first write. The registered result appears on `read` one
// cycle later. Any access outside the window [BASE_ADDR, BASE_ADDR+2^DEPTH_LOG2)
// sets the sticky `err` flag.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   rw        - CPU access type, 1 = write, 0 = read
//   addr      - CPU word address
//   write     - CPU write data
//   read      - registered read data (0 in LOAD or when out of window)
//   ready     - high in RUN; CPU accesses honoured only then
//   ld_valid  - loader word valid
//   ld_data   - loader word
//   ld_last   - marks the final loader word
//   ld_ready  - loader may transfer (high in LOAD)
//   ld_count  - number of words loaded since reset
//   err       - sticky out-of-window access flag

`ifndef INITIAL_PC
`define INITIAL_PC 64'h0
`endif

module zipomem #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = `INITIAL_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rw,
  input  logic [63:0]           addr,
  input  logic [63:0]           write,
  output logic [63:0]           read,
  output logic                  ready,
  input  logic                  ld_valid,
  input  logic [63:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic [DEPTH_LOG2:0]   ld_count,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [63:0]           read_q, read_d;
  logic                  err_q, err_d;

  logic [63:0]           mem [DEPTH];

  logic [63:0]           idx;
  logic                  inWin;
  logic [DEPTH_LOG2-1:0] memIdx;
  logic                  memWe;
  logic [DEPTH_LOG2-1:0] memWaddr;
  logic [63:0]           memWdata;

  // Modular subtraction, so addresses below BASE_ADDR wrap to huge indices
  // and fall out of the window.
  assign idx    = addr - BASE_ADDR;
  assign inWin  = (idx >> DEPTH_LOG2) == 64'd0;
  assign memIdx = idx[DEPTH_LOG2-1:0];

  // Next-state logic for the loader and the CPU port. The array read here is
  // the pre-edge contents, which gives read-first behaviour on writes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    read_d   = 64'd0;
    err_d    = err_q;
    memWe    = 1'b0;
    memWaddr = ptr_q;
    memWdata = ld_data;
    case (state_q)
      LOAD: begin
        if (ld_valid) begin
          memWe    = 1'b1;
          memWaddr = ptr_q;
          memWdata = ld_data;
          ptr_d    = ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // A full array ends the load even without ld_last.
          if (ld_last || (ptr_q == '1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (inWin) begin
          read_d = mem[memIdx];
          if (rw) begin
            memWe    = 1'b1;
            memWaddr = memIdx;
            memWdata = write;
          end
        end else begin
          read_d = 64'd0;
          err_d  = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers. Reset does not touch the array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      read_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      err_q   <= err_d;
    end
  end

  // Array write port, shared by the loader and CPU writes. Writes are
  // suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  assign read     = read_q;
  assign ready    = (state_q == RUN);
  assign ld_ready = (state_q == LOAD);
  assign ld_count = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_zipomem.sv
// tb_zipomem: self-checking bench for zipomem.
//
// Instance A uses a 16-word window at base 0x100. It covers the load, read,
// read-first write, out-of-window err, random traffic and reset-in-RUN
// scenarios. Instance B uses a 4-word array at base 0 and covers the load
// that ends because the array is full.
// Expected values come from a plain array model of the memory window.

module tb_zipomem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        aRw, aLdValid, aLdLast;
  logic [63:0] aAddr, aWrite, aLdData;
  logic [63:0] aRead;
  logic        aReady, aLdReady, aErr;
  logic [4:0]  aLdCount;

  logic        bRw, bLdValid, bLdLast;
  logic [63:0] bAddr, bWrite, bLdData;
  logic [63:0] bRead;
  logic        bReady, bLdReady, bErr;
  logic [2:0]  bLdCount;

  zipomem #(.DEPTH_LOG2(4), .BASE_ADDR(64'h100)) dutA (
    .clk(clk), .rst_n(rst_n), .rw(aRw), .addr(aAddr), .write(aWrite),
    .read(aRead), .ready(aReady), .ld_valid(aLdValid), .ld_data(aLdData),
    .ld_last(aLdLast), .ld_ready(aLdReady), .ld_count(aLdCount), .err(aErr)
  );

  zipomem #(.DEPTH_LOG2(2), .BASE_ADDR(64'h0)) dutB (
    .clk(clk), .rst_n(rst_n), .rw(bRw), .addr(bAddr), .write(bWrite),
    .read(bRead), .ready(bReady), .ld_valid(bLdValid), .ld_data(bLdData),
    .ld_last(bLdLast), .ld_ready(bLdReady), .ld_count(bLdCount), .err(bErr)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] modelA [16];
  logic        expErr;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] idx;
    logic [63:0] expRead;
    int          sel;

    rst_n = 1'b0;
    aRw = 1'b0; aAddr = 64'h0; aWrite = 64'h0;
    aLdValid = 1'b0; aLdData = 64'h0; aLdLast = 1'b0;
    bRw = 1'b0; bAddr = 64'h0; bWrite = 64'h0;
    bLdValid = 1'b0; bLdData = 64'h0; bLdLast = 1'b0;
    expErr = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_read",     aRead,    64'h0);
    checkOutput("rst_ready",    aReady,   64'h0);
    checkOutput("rst_ld_ready", aLdReady, 64'h1);
    checkOutput("rst_ld_count", aLdCount, 64'h0);
    checkOutput("rst_err",      aErr,     64'h0);
    rst_n = 1'b1;

    // Load four words while the CPU side tries to write 0xDEAD to index 0.
    $display("[TB] loading instance A");
    aRw = 1'b1; aAddr = 64'h100; aWrite = 64'hDEAD;
    aLdValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aLdData = 64'h11 * (i + 1);
      aLdLast = (i == 3);
      modelA[i] = aLdData;
      applyStimulus();
      checkOutput("load_read", aRead, 64'h0);
      if (i < 3) checkOutput("load_not_ready", aReady, 64'h0);
    end
    aLdValid = 1'b0; aLdLast = 1'b0;
    checkOutput("load_count",    aLdCount, 64'd4);
    checkOutput("load_ready",    aReady,   64'h1);
    checkOutput("load_ld_ready", aLdReady, 64'h0);

    aRw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      aAddr = 64'h100 + 64'(i);
      applyStimulus();
      checkOutput("loaded_read", aRead, modelA[i]);
    end

    // Read-first write followed by a read of the same index.
    aRw = 1'b1; aAddr = 64'h102; aWrite = 64'hCAFE;
    applyStimulus();
    checkOutput("wr_old_value", aRead, 64'h33);
    modelA[2] = 64'hCAFE;
    aRw = 1'b0;
    applyStimulus();
    checkOutput("rd_after_wr", aRead, 64'hCAFE);

    // Top of window is valid; just below base is out of window.
    aRw = 1'b1; aAddr = 64'h10F; aWrite = 64'h0F0F_1234_5678_ABCD;
    modelA[15] = aWrite;
    applyStimulus();
    checkOutput("err_clear", aErr, 64'h0);
    aRw = 1'b0;
    applyStimulus();
    checkOutput("rd_top", aRead, modelA[15]);
    aAddr = 64'hFF;
    applyStimulus();
    checkOutput("rd_below_base", aRead, 64'h0);
    checkOutput("err_set",       aErr,  64'h1);
    aAddr = 64'h100;
    applyStimulus();
    checkOutput("rd_after_err", aRead, modelA[0]);
    checkOutput("err_sticky",   aErr,  64'h1);
    expErr = 1'b1;

    // Give every index a known value before random traffic.
    aRw = 1'b1;
    for (int i = 4; i < 15; i++) begin
      aAddr  = 64'h100 + 64'(i);
      aWrite = {$urandom, $urandom};
      modelA[i] = aWrite;
      applyStimulus();
    end

    $display("[TB] random traffic on instance A");
    for (int n = 0; n < 300; n++) begin
      aRw    = 1'($urandom_range(0, 1));
      aWrite = {$urandom, $urandom};
      sel    = $urandom_range(0, 5);
      if (sel < 4)       aAddr = 64'h100 + 64'($urandom_range(0, 15));
      else if (sel == 4) aAddr = 64'hFF - 64'($urandom_range(0, 3));
      else               aAddr = {$urandom, $urandom};
      idx = aAddr - 64'h100;
      if (idx < 64'd16) begin
        expRead = modelA[idx[3:0]];
        if (aRw) modelA[idx[3:0]] = aWrite;
      end else begin
        expRead = 64'h0;
        expErr  = 1'b1;
      end
      applyStimulus();
      checkOutput("rand_read", aRead, expRead);
      checkOutput("rand_err",  aErr,  64'(expErr));
    end
    aRw = 1'b0; aAddr = 64'h100;

    // Instance B has been stalled in LOAD until now; offer six words, no ld_last.
    $display("[TB] overfill on instance B");
    checkOutput("b_stalled_count", bLdCount, 64'd0);
    bLdValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bLdData = 64'h50 + 64'(i);
      checkOutput("b_ld_ready", bLdReady, (i < 4) ? 64'h1 : 64'h0);
      applyStimulus();
    end
    bLdValid = 1'b0;
    checkOutput("b_ld_count", bLdCount, 64'd4);
    checkOutput("b_ready",    bReady,   64'h1);
    for (int i = 0; i < 4; i++) begin
      bAddr = 64'(i);
      applyStimulus();
      checkOutput("b_read", bRead, 64'h50 + 64'(i));
    end

    // One-cycle reset in RUN, then a two-word reload.
    $display("[TB] reset in RUN and reload");
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("rerst_ready",    aReady,   64'h0);
    checkOutput("rerst_ld_ready", aLdReady, 64'h1);
    checkOutput("rerst_ld_count", aLdCount, 64'h0);
    checkOutput("rerst_err",      aErr,     64'h0);
    checkOutput("rerst_read",     aRead,    64'h0);
    rst_n = 1'b1;
    aLdValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      aLdData = 64'hA1 + 64'(i);
      aLdLast = (i == 1);
      modelA[i] = aLdData;
      applyStimulus();
    end
    aLdValid = 1'b0; aLdLast = 1'b0;
    checkOutput("reload_count", aLdCount, 64'd2);
    checkOutput("reload_ready", aReady,   64'h1);
    for (int i = 0; i < 3; i++) begin
      aAddr = 64'h100 + 64'(i);
      applyStimulus();
      checkOutput("reload_read", aRead, modelA[i]);
    end
    checkOutput("reload_err", aErr, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
